// File: rtl/usb_pkg.sv
// Shared types and constants for the USB SIE packet agent.
package usb_pkg;

  localparam int BUS_RST_CNT_W = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_DONE
  } tx_state_e;

  typedef enum logic {
    RX_IDLE,
    RX_RECV
  } rx_state_e;

endpackage

// File: rtl/usb_sie_pkt_buf.sv
// Simple dual-port byte RAM with registered read; a same-cycle write to the
// read address is forwarded so the read always returns post-write contents.
module usb_sie_pkt_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    rd_q <= (wr_en_i && (wr_addr_i == rd_addr_i)) ? wr_data_i : mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/usb_sie_pkt_agent.sv
// Packet agent between a byte-level USB SIE and local TX/RX packet buffers,
// with independent TX and RX state machines and a bus-reset event counter.
module usb_sie_pkt_agent
  import usb_pkg::*;
#(
  parameter int TX_DEPTH = 64,
  parameter int RX_DEPTH = 64,
  parameter int LEN_W    = $clog2((TX_DEPTH > RX_DEPTH) ? TX_DEPTH : RX_DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tx_wr_en,
  input  logic [$clog2(TX_DEPTH)-1:0] tx_wr_addr,
  input  logic [7:0]                  tx_wr_data,
  input  logic [LEN_W-1:0]            tx_len,
  input  logic                        tx_start,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic                        tx_abort,
  output logic [7:0]                  sie_tx_data,
  output logic                        sie_tx_valid,
  input  logic                        sie_tx_ready,
  input  logic [7:0]                  sie_rx_data,
  input  logic                        sie_rx_valid,
  input  logic                        sie_rx_active,
  input  logic                        sie_rx_error,
  input  logic                        sie_reset,
  input  logic [$clog2(RX_DEPTH)-1:0] rx_rd_addr,
  output logic [7:0]                  rx_rd_data,
  output logic                        rx_pkt_valid,
  output logic [LEN_W-1:0]            rx_len,
  output logic                        rx_err,
  output logic                        rx_ovf,
  output logic [BUS_RST_CNT_W-1:0]    bus_reset_cnt
);

  localparam int TXA_W = $clog2(TX_DEPTH);
  localparam int RXA_W = $clog2(RX_DEPTH);
  localparam logic [LEN_W-1:0] TX_MAX = LEN_W'(TX_DEPTH);
  localparam logic [LEN_W-1:0] RX_MAX = LEN_W'(RX_DEPTH);

  tx_state_e        tx_state_q, tx_state_d;
  logic [LEN_W-1:0] tx_idx_q, tx_idx_d, tx_len_q, tx_len_d, tx_len_clamped;
  logic             tx_abort_q, tx_abort_d;
  logic [7:0]       tx_rd_data;

  rx_state_e        rx_state_q, rx_state_d;
  logic [LEN_W-1:0] rx_cnt_q, rx_cnt_d, rx_len_q, rx_len_d;
  logic             rx_err_q, rx_err_d, rx_ovf_q, rx_ovf_d, rx_pkt_q, rx_pkt_d;
  logic             rx_act_prev_q, rx_we;

  logic                     sie_reset_prev_q;
  logic [BUS_RST_CNT_W-1:0] bus_rst_cnt_q;

  assign tx_len_clamped = (tx_len > TX_MAX) ? TX_MAX : tx_len;

  // The RAM is addressed with the next index so the byte for the coming SEND
  // cycle is already registered when that cycle starts.
  usb_sie_pkt_buf #(.DEPTH(TX_DEPTH)) u_tx_buf (
    .clk       (clk),
    .wr_en_i   (tx_wr_en),
    .wr_addr_i (tx_wr_addr),
    .wr_data_i (tx_wr_data),
    .rd_addr_i (tx_idx_d[TXA_W-1:0]),
    .rd_data_o (tx_rd_data)
  );

  usb_sie_pkt_buf #(.DEPTH(RX_DEPTH)) u_rx_buf (
    .clk       (clk),
    .wr_en_i   (rx_we),
    .wr_addr_i (rx_cnt_q[RXA_W-1:0]),
    .wr_data_i (sie_rx_data),
    .rd_addr_i (rx_rd_addr),
    .rd_data_o (rx_rd_data)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_idx_d   = tx_idx_q;
    tx_len_d   = tx_len_q;
    tx_abort_d = tx_abort_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_start) begin
          tx_idx_d   = '0;
          tx_len_d   = tx_len_clamped;
          tx_abort_d = 1'b0;
          tx_state_d = (tx_len_clamped == '0) ? TX_DONE : TX_SEND;
        end
      end
      TX_SEND: begin
        if (sie_reset) begin
          tx_abort_d = 1'b1;
          tx_state_d = TX_DONE;
        end else if (sie_tx_ready) begin
          if (tx_idx_q == tx_len_q - LEN_W'(1)) tx_state_d = TX_DONE;
          else                                  tx_idx_d   = tx_idx_q + LEN_W'(1);
        end
      end
      TX_DONE: tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_idx_q   <= '0;
      tx_len_q   <= '0;
      tx_abort_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_idx_q   <= tx_idx_d;
      tx_len_q   <= tx_len_d;
      tx_abort_q <= tx_abort_d;
    end
  end

  assign tx_busy      = (tx_state_q != TX_IDLE);
  assign tx_done      = (tx_state_q == TX_DONE);
  assign tx_abort     = (tx_state_q == TX_DONE) && tx_abort_q;
  assign sie_tx_valid = (tx_state_q == TX_SEND);
  assign sie_tx_data  = sie_tx_valid ? tx_rd_data : '0;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_len_d   = rx_len_q;
    rx_err_d   = rx_err_q;
    rx_ovf_d   = rx_ovf_q;
    rx_pkt_d   = 1'b0;
    rx_we      = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (sie_rx_active && !rx_act_prev_q) begin
          rx_state_d = RX_RECV;
          rx_cnt_d   = '0;
          rx_err_d   = 1'b0;
          rx_ovf_d   = 1'b0;
        end
      end
      RX_RECV: begin
        // In RECV the previous active sample is always 1, so low active is the falling edge.
        if (sie_reset) begin
          rx_state_d = RX_IDLE;
        end else if (!sie_rx_active) begin
          rx_len_d   = rx_cnt_q;
          rx_pkt_d   = 1'b1;
          rx_state_d = RX_IDLE;
        end else begin
          if (sie_rx_valid) begin
            if (rx_cnt_q < RX_MAX) begin
              rx_we    = 1'b1;
              rx_cnt_d = rx_cnt_q + LEN_W'(1);
            end else begin
              rx_ovf_d = 1'b1;
            end
          end
          if (sie_rx_error) rx_err_d = 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q       <= RX_IDLE;
      rx_cnt_q         <= '0;
      rx_len_q         <= '0;
      rx_err_q         <= 1'b0;
      rx_ovf_q         <= 1'b0;
      rx_pkt_q         <= 1'b0;
      rx_act_prev_q    <= 1'b0;
      sie_reset_prev_q <= 1'b0;
      bus_rst_cnt_q    <= '0;
    end else begin
      rx_state_q       <= rx_state_d;
      rx_cnt_q         <= rx_cnt_d;
      rx_len_q         <= rx_len_d;
      rx_err_q         <= rx_err_d;
      rx_ovf_q         <= rx_ovf_d;
      rx_pkt_q         <= rx_pkt_d;
      rx_act_prev_q    <= sie_rx_active;
      sie_reset_prev_q <= sie_reset;
      if (sie_reset && !sie_reset_prev_q && (bus_rst_cnt_q != '1))
        bus_rst_cnt_q <= bus_rst_cnt_q + BUS_RST_CNT_W'(1);
    end
  end

  assign rx_pkt_valid  = rx_pkt_q;
  assign rx_len        = rx_len_q;
  assign rx_err        = rx_err_q;
  assign rx_ovf        = rx_ovf_q;
  assign bus_reset_cnt = bus_rst_cnt_q;

endmodule

// File: tb/tb_usb_sie_pkt_agent.sv
// Bench for usb_sie_pkt_agent: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_usb_sie_pkt_agent;

  localparam int TXD = 16;
  localparam int RXD = 8;
  localparam int LW  = 5;

  logic       clk = 1'b0, rst = 1'b1;
  logic       tx_wr_en = 1'b0, tx_start = 1'b0, sie_tx_ready = 1'b0;
  logic [3:0] tx_wr_addr = '0;
  logic [7:0] tx_wr_data = '0, sie_rx_data = '0;
  logic [LW-1:0] tx_len = '0;
  logic       sie_rx_valid = 1'b0, sie_rx_active = 1'b0, sie_rx_error = 1'b0, sie_reset = 1'b0;
  logic [2:0] rx_rd_addr = '0;
  logic       tx_busy, tx_done, tx_abort, sie_tx_valid, rx_pkt_valid, rx_err, rx_ovf;
  logic [7:0] sie_tx_data, rx_rd_data, bus_reset_cnt;
  logic [LW-1:0] rx_len;

  always #5 clk = ~clk;

  usb_sie_pkt_agent #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk(clk), .rst(rst),
    .tx_wr_en(tx_wr_en), .tx_wr_addr(tx_wr_addr), .tx_wr_data(tx_wr_data),
    .tx_len(tx_len), .tx_start(tx_start), .tx_busy(tx_busy), .tx_done(tx_done),
    .tx_abort(tx_abort), .sie_tx_data(sie_tx_data), .sie_tx_valid(sie_tx_valid),
    .sie_tx_ready(sie_tx_ready), .sie_rx_data(sie_rx_data), .sie_rx_valid(sie_rx_valid),
    .sie_rx_active(sie_rx_active), .sie_rx_error(sie_rx_error), .sie_reset(sie_reset),
    .rx_rd_addr(rx_rd_addr), .rx_rd_data(rx_rd_data), .rx_pkt_valid(rx_pkt_valid),
    .rx_len(rx_len), .rx_err(rx_err), .rx_ovf(rx_ovf), .bus_reset_cnt(bus_reset_cnt)
  );

  int checks = 0, failures = 0;
  bit cmp_on = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int         m_tx_phase = 0;  // 0 idle, 1 bytes outstanding, 2 completion pulse
  int         m_tx_len = 0, m_tx_pos = 0;
  bit         m_tx_ab = 0;
  logic [7:0] m_txmem [TXD];
  bit         m_txdef [TXD];
  bit         m_rx_in = 0, m_rx_err = 0, m_rx_ovf = 0, m_rx_pkt = 0, m_act_prev = 0, m_rst_prev = 0;
  int         m_rx_cnt = 0, m_rx_len = 0, m_brc = 0;
  logic [7:0] m_rxmem [RXD];
  bit         m_rxdef [RXD];
  logic [7:0] m_rd_val;
  bit         m_rd_def = 0;

  always @(posedge clk) begin : model
    int nlen;
    if (tx_wr_en) begin
      m_txmem[tx_wr_addr] = tx_wr_data;
      m_txdef[tx_wr_addr] = 1;
    end
    if (rst) begin
      m_tx_phase = 0; m_tx_ab = 0;
      m_rx_in = 0; m_rx_len = 0; m_rx_err = 0; m_rx_ovf = 0; m_rx_pkt = 0;
      m_act_prev = 0; m_rst_prev = 0; m_brc = 0;
      foreach (m_txdef[i]) m_txdef[i] = 0;
      foreach (m_rxdef[i]) m_rxdef[i] = 0;
    end else begin
      if (m_tx_phase == 1) begin
        if (sie_reset) begin
          m_tx_phase = 2; m_tx_ab = 1;
        end else if (sie_tx_ready) begin
          m_tx_pos++;
          if (m_tx_pos == m_tx_len) m_tx_phase = 2;
        end
      end else if (m_tx_phase == 2) begin
        m_tx_phase = 0;
      end else if (tx_start) begin
        nlen = (int'(tx_len) > TXD) ? TXD : int'(tx_len);
        m_tx_len = nlen; m_tx_pos = 0; m_tx_ab = 0;
        m_tx_phase = (nlen == 0) ? 2 : 1;
      end
      m_rx_pkt = 0;
      if (!m_rx_in) begin
        if (sie_rx_active && !m_act_prev) begin
          m_rx_in = 1; m_rx_cnt = 0; m_rx_err = 0; m_rx_ovf = 0;
        end
      end else if (sie_reset) begin
        m_rx_in = 0;
      end else if (!sie_rx_active) begin
        m_rx_len = m_rx_cnt; m_rx_pkt = 1; m_rx_in = 0;
      end else begin
        if (sie_rx_valid) begin
          if (m_rx_cnt < RXD) begin
            m_rxmem[m_rx_cnt] = sie_rx_data;
            m_rxdef[m_rx_cnt] = 1;
            m_rx_cnt++;
          end else m_rx_ovf = 1;
        end
        if (sie_rx_error) m_rx_err = 1;
      end
      m_act_prev = sie_rx_active;
      if (sie_reset && !m_rst_prev && m_brc < 255) m_brc++;
      m_rst_prev = sie_reset;
    end
    m_rd_val = m_rxmem[rx_rd_addr];
    m_rd_def = m_rxdef[rx_rd_addr];
    cmp_on = 1;
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("busy", tx_busy, (m_tx_phase != 0));
      chk("done", tx_done, (m_tx_phase == 2));
      chk("abort", tx_abort, (m_tx_phase == 2 && m_tx_ab));
      chk("txvalid", sie_tx_valid, (m_tx_phase == 1));
      if (m_tx_phase == 1) begin
        if (m_txdef[m_tx_pos]) chk("txdata", sie_tx_data, m_txmem[m_tx_pos]);
      end else chk("txdata_idle", sie_tx_data, 0);
      chk("pkt", rx_pkt_valid, m_rx_pkt);
      chk("rxlen", rx_len, m_rx_len);
      chk("rxerr", rx_err, m_rx_err);
      chk("rxovf", rx_ovf, m_rx_ovf);
      chk("brc", bus_reset_cnt, m_brc);
      if (m_rd_def) chk("rdata", rx_rd_data, m_rd_val);
    end
  end

  logic [7:0] sent[$];
  int vcount = 0;
  always @(negedge clk) begin
    if (!rst && sie_tx_valid) begin
      vcount++;
      if (sie_tx_ready && !sie_reset) sent.push_back(sie_tx_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_tx(input logic [3:0] a, input logic [7:0] d);
    tx_wr_en = 1; tx_wr_addr = a; tx_wr_data = d;
    tick();
    tx_wr_en = 0;
  endtask

  task automatic start_tx(input int len);
    tx_len = LW'(len); tx_start = 1;
    tick();
    tx_start = 0;
  endtask

  logic [7:0] pkt_q[$];
  task automatic rx_pkt(input int err_at);
    sie_rx_active = 1; sie_rx_valid = 0; sie_rx_error = 0;
    tick();
    foreach (pkt_q[i]) begin
      sie_rx_valid = 1; sie_rx_data = pkt_q[i]; sie_rx_error = (i == err_at);
      tick();
    end
    sie_rx_active = 0; sie_rx_valid = 0; sie_rx_error = 0;
    tick();
  endtask

  logic [7:0] p032 [4] = '{8'hA5, 8'h01, 8'h02, 8'h03};
  logic [7:0] p034 [5] = '{8'h2D, 8'h00, 8'h10, 8'hE8, 8'h4B};

  initial begin
    int stall, vs;
    repeat (3) tick();
    chk("rst_busy", tx_busy, 0);
    chk("rst_valid", sie_tx_valid, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_pkt", rx_pkt_valid, 0);
    chk("rst_rxlen", rx_len, 0);
    chk("rst_brc", bus_reset_cnt, 0);
    rst = 0;
    tick();

    // four bytes, ready held high
    for (int i = 0; i < 4; i++) write_tx(4'(i), p032[i]);
    sie_tx_ready = 1; sent.delete(); vs = vcount;
    start_tx(4);
    for (int n = 0; n < 20 && !tx_done; n++) tick();
    chk("t32_done", tx_done, 1);
    chk("t32_abort", tx_abort, 0);
    chk("t32_vcycles", vcount - vs, 4);
    chk("t32_count", sent.size(), 4);
    for (int i = 0; i < 4 && i < sent.size(); i++) chk("t32_byte", sent[i], p032[i]);
    tick();

    // stall three cycles on the third byte
    sent.delete(); stall = 0;
    start_tx(4);
    for (int n = 0; n < 40 && !tx_done; n++) begin
      if (sie_tx_valid && sent.size() == 2) chk("t33_hold", sie_tx_data, 8'h02);
      if (sie_tx_valid && sent.size() == 2 && stall < 3) begin
        sie_tx_ready = 0; stall++;
      end else sie_tx_ready = 1;
      tick();
    end
    sie_tx_ready = 1;
    chk("t33_done", tx_done, 1);
    chk("t33_stalls", stall, 3);
    chk("t33_count", sent.size(), 4);
    for (int i = 0; i < 4 && i < sent.size(); i++) chk("t33_byte", sent[i], p032[i]);
    tick();

    // five-byte receive and readback
    pkt_q = {p034[0], p034[1], p034[2], p034[3], p034[4]};
    rx_pkt(-1);
    chk("r34_pkt", rx_pkt_valid, 1);
    chk("r34_len", rx_len, 5);
    chk("r34_err", rx_err, 0);
    chk("r34_ovf", rx_ovf, 0);
    for (int i = 0; i < 5; i++) begin
      rx_rd_addr = 3'(i);
      tick();
      chk("r34_rd", rx_rd_data, p034[i]);
    end

    // overflow
    pkt_q.delete();
    for (int i = 0; i < RXD + 3; i++) pkt_q.push_back(8'($urandom));
    rx_pkt(-1);
    chk("r35_ovf", rx_ovf, 1);
    chk("r35_len", rx_len, RXD);
    for (int i = 0; i < RXD; i++) begin
      rx_rd_addr = 3'(i);
      tick();
      chk("r35_rd", rx_rd_data, pkt_q[i]);
    end

    // sticky error, cleared by the next packet; then zero-byte packet
    pkt_q = {8'h11, 8'h22, 8'h33, 8'h44};
    rx_pkt(1);
    chk("r36_err", rx_err, 1);
    chk("r36_len", rx_len, 4);
    pkt_q = {8'h55, 8'h66, 8'h77};
    rx_pkt(-1);
    chk("r36_clr", rx_err, 0);
    chk("r36_ovfclr", rx_ovf, 0);
    pkt_q.delete();
    rx_pkt(-1);
    chk("r22_pkt", rx_pkt_valid, 1);
    chk("r22_len", rx_len, 0);
    tick();

    // rst in the middle of a transmit
    start_tx(8);
    tick();
    chk("t29_valid", sie_tx_valid, 1);
    rst = 1;
    tick();
    chk("t29_drop", sie_tx_valid, 0);
    chk("t29_nodone", tx_done, 0);
    rst = 0;
    tick();
    chk("t29_nodone2", tx_done, 0);

    // bus reset at byte 3 of an 8-byte transmit, then zero-length start
    for (int i = 0; i < 8; i++) write_tx(4'(i), 8'(8'h40 + i));
    sent.delete(); sie_tx_ready = 1;
    start_tx(8);
    for (int n = 0; n < 40 && !(sie_tx_valid && sent.size() == 3); n++) tick();
    chk("t37_at3", sent.size(), 3);
    sie_reset = 1;
    tick();
    sie_reset = 0;
    chk("t37_done", tx_done, 1);
    chk("t37_abort", tx_abort, 1);
    chk("t37_valid", sie_tx_valid, 0);
    chk("t37_brc", bus_reset_cnt, 1);
    tick();
    chk("t37_idle", tx_busy, 0);
    chk("t37_sent", sent.size(), 3);
    vs = vcount;
    start_tx(0);
    chk("t06_done", tx_done, 1);
    chk("t06_abort", tx_abort, 0);
    tick();
    chk("t06_novalid", vcount - vs, 0);
    chk("t06_idle", tx_busy, 0);

    // randomized concurrent traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 399) == 0);
      sie_reset = ($urandom_range(0, 79) == 0);
      sie_tx_ready = ($urandom_range(0, 3) != 0);
      tx_start = ($urandom_range(0, 9) == 0);
      tx_len = LW'($urandom_range(0, 20));
      tx_wr_en = 0;
      if ($urandom_range(0, 1) == 1) begin
        if (m_tx_phase != 1) begin
          tx_wr_en = 1; tx_wr_addr = 4'($urandom);
        end else if (m_tx_pos < TXD - 1) begin
          tx_wr_en = 1; tx_wr_addr = 4'($urandom_range(TXD - 1, m_tx_pos + 1));
        end
      end
      tx_wr_data = 8'($urandom);
      if (!sie_rx_active) begin
        sie_rx_active = ($urandom_range(0, 5) == 0);
        sie_rx_valid = 0; sie_rx_error = 0;
      end else begin
        sie_rx_active = ($urandom_range(0, 9) != 0);
        sie_rx_valid = sie_rx_active && ($urandom_range(0, 2) != 0);
        sie_rx_error = sie_rx_active && ($urandom_range(0, 29) == 0);
      end
      sie_rx_data = 8'($urandom);
      rx_rd_addr = 3'($urandom);
      tick();
    end
    rst = 0; sie_reset = 0; tx_start = 0; tx_wr_en = 0;
    sie_rx_active = 0; sie_rx_valid = 0; sie_rx_error = 0;
    repeat (5) tick();

    // bus reset counter saturation
    for (int i = 0; i < 260; i++) begin
      sie_reset = 1; tick();
      sie_reset = 0; tick();
    end
    chk("brc_sat", bus_reset_cnt, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
